// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Owner tag records which requester a granted read belongs to; memory answers one cycle later.
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    DM   = 2'd2
  } rd_owner_t;

  localparam int MEM_READ_LATENCY = 1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port sync memory: combinational grant, read data one cycle later.
// Losers hold their request until granted; MEM_ARB_ROUND_ROBIN_EN selects alternating priority on conflict.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int CPU_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_req,
  input  logic [ADDRESS_WIDTH-1:0]      if_addr,
  output logic                          if_gnt,
  output logic                          if_rvalid,
  output logic [CPU_DATA_WIDTH-1:0]     if_rdata,
  input  logic                          dm_req,
  input  logic                          dm_we,
  input  logic [CPU_DATA_WIDTH/8-1:0]   dm_be,
  input  logic                          dm_lock,
  input  logic [ADDRESS_WIDTH-1:0]      dm_addr,
  input  logic [CPU_DATA_WIDTH-1:0]     dm_wdata,
  output logic                          dm_gnt,
  output logic                          dm_rvalid,
  output logic [CPU_DATA_WIDTH-1:0]     dm_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [CPU_DATA_WIDTH/8-1:0]   mem_be,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  output logic [CPU_DATA_WIDTH-1:0]     mem_wdata,
  input  logic [CPU_DATA_WIDTH-1:0]     mem_rdata
);

  arb_state_t r_state;
  rd_owner_t  r_owner;
  logic       w_dm_wins;
  logic       w_if_gnt;
  logic       w_dm_gnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_if_pri;
  logic w_conflict;

  assign w_dm_wins  = ~r_if_pri;
  assign w_conflict = (r_state == ARB) & if_req & dm_req;

  // Each conflict hands priority to the port that just lost it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_pri <= 1'b0;
    end else if (w_conflict) begin
      r_if_pri <= ~r_if_pri;
    end
  end
`else
  assign w_dm_wins = 1'b1;
`endif

  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (rst) begin
      if (r_state == LOCKED) begin
        w_dm_gnt = dm_req;
      end else begin
        w_dm_gnt = dm_req & (~if_req | w_dm_wins);
        w_if_gnt = if_req & ~w_dm_gnt;
      end
    end
  end

  assign if_gnt = w_if_gnt;
  assign dm_gnt = w_dm_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (w_if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

  // The lock bit travels with each data access, so the last dm grant decides ownership.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB;
      r_owner <= NONE;
    end else begin
      if (w_dm_gnt) begin
        r_state <= dm_lock ? LOCKED : ARB;
      end
      if (w_dm_gnt && !dm_we) begin
        r_owner <= DM;
      end else if (w_if_gnt) begin
        r_owner <= IF;
      end else begin
        r_owner <= NONE;
      end
    end
  end

  assign if_rvalid = rst & (r_owner == IF);
  assign dm_rvalid = rst & (r_owner == DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a request-level model.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_lock, dm_gnt, dm_rvalid;
  logic [BW-1:0] dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .CPU_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_lock(dm_lock),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory; bus carries noise on cycles without a read.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    else                   mem_rdata <= $urandom;
    if (mem_en && mem_we)
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  task automatic drive_idle();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_lock = 0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0;
    drive_idle();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    if_req = 1; if_addr = 10'h005;
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 10'h006; dm_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_en, mem_we,
           mem_be, mem_addr, mem_wdata} !== '0) begin
        bad++;
        $display("FAIL reset_outputs c=%0d: gnt=%b%b rv=%b%b en=%b addr=%h wdata=%h want all zero",
                 c, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_addr, mem_wdata);
      end
    end
    drive_idle();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_solo_fetch();
    mem[10'h010] = 32'h0050_0093;
    if_req = 1; if_addr = 10'h010;
    @(negedge clk);
    total++;
    if ({if_gnt, dm_gnt, mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'h010}) begin
      bad++;
      $display("FAIL solo_grant: gnt=%b%b en=%b we=%b be=%h addr=%h want 10 1 0 f 010",
               if_gnt, dm_gnt, mem_en, mem_we, mem_be, mem_addr);
    end
    next_cycle();
    if_req = 0;
    @(negedge clk);
    total++;
    if ({if_rvalid, if_rdata, dm_rvalid} !== {1'b1, 32'h0050_0093, 1'b0}) begin
      bad++;
      $display("FAIL solo_rdata: if_rv=%b if_rdata=%h dm_rv=%b want 1 00500093 0",
               if_rvalid, if_rdata, dm_rvalid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({if_rvalid, if_rdata, dm_rvalid, dm_rdata, mem_en} !== '0) begin
      bad++;
      $display("FAIL solo_quiet: if_rv=%b if_rdata=%h dm_rv=%b en=%b want all zero",
               if_rvalid, if_rdata, dm_rvalid, mem_en);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    mem[10'h020] = 32'hA5A5_0020;
    mem[10'h011] = 32'h0011_B00B;
    if_req = 1; if_addr = 10'h011;
    dm_req = 1; dm_we = 0; dm_addr = 10'h020;
`ifndef MEM_ARB_ROUND_ROBIN_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({if_gnt, dm_gnt, mem_addr} !== {1'b0, 1'b1, 10'h020}) begin
        bad++;
        $display("FAIL fixed_conflict c=%0d: if_gnt=%b dm_gnt=%b addr=%h want 0 1 020", c, if_gnt, dm_gnt, mem_addr);
      end
      if (c > 0) begin
        total++;
        if ({dm_rvalid, dm_rdata, if_rvalid} !== {1'b1, 32'hA5A5_0020, 1'b0}) begin
          bad++;
          $display("FAIL fixed_dm_rdata c=%0d: dm_rv=%b dm_rdata=%h if_rv=%b want 1 a5a50020 0",
                   c, dm_rvalid, dm_rdata, if_rvalid);
        end
      end
      next_cycle();
    end
    dm_req = 0;
    @(negedge clk);
    total++;
    if ({if_gnt, dm_gnt, mem_addr, dm_rvalid} !== {1'b1, 1'b0, 10'h011, 1'b1}) begin
      bad++;
      $display("FAIL fixed_if_after_drop: if_gnt=%b dm_gnt=%b addr=%h dm_rv=%b want 1 0 011 1",
               if_gnt, dm_gnt, mem_addr, dm_rvalid);
    end
    next_cycle();
    if_req = 0;
    @(negedge clk);
    total++;
    if ({if_rvalid, if_rdata, dm_rvalid} !== {1'b1, 32'h0011_B00B, 1'b0}) begin
      bad++;
      $display("FAIL fixed_if_rdata: if_rv=%b if_rdata=%h dm_rv=%b want 1 0011b00b 0",
               if_rvalid, if_rdata, dm_rvalid);
    end
`else
    for (int c = 0; c < 5; c++) begin
      if (c == 4) drive_idle();
      @(negedge clk);
      if (c < 4) begin
        total++;
        if ({if_gnt, dm_gnt} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
          bad++;
          $display("FAIL rr_conflict c=%0d: if_gnt=%b dm_gnt=%b want dm=%0d", c, if_gnt, dm_gnt, c % 2 == 0);
        end
      end
      if (c > 0) begin
        total++;
        if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !==
            ((c % 2 == 1) ? {2'b01, 32'h0, 32'hA5A5_0020} : {2'b10, 32'h0011_B00B, 32'h0})) begin
          bad++;
          $display("FAIL rr_rvalid c=%0d: rv=%b%b if_rdata=%h dm_rdata=%h", c, if_rvalid, dm_rvalid, if_rdata, dm_rdata);
        end
      end
      next_cycle();
    end
`endif
    drive_idle();
  endtask

  task automatic test_locked_rmw();
    do_reset();
    mem[10'h030] = 32'h1234_5678;
    if_req = 1; if_addr = 10'h012;
    dm_req = 1; dm_we = 0; dm_lock = 1; dm_addr = 10'h030;
    @(negedge clk);
    total++;
    if ({if_gnt, dm_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL rmw_read_gnt: if_gnt=%b dm_gnt=%b want 0 1", if_gnt, dm_gnt);
    end
    next_cycle();
    dm_req = 0; dm_lock = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
        bad++;
        $display("FAIL rmw_locked_idle c=%0d: if_gnt=%b dm_gnt=%b en=%b want 000", c, if_gnt, dm_gnt, mem_en);
      end
      if (c == 0) begin
        total++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h1234_5678}) begin
          bad++;
          $display("FAIL rmw_read_data: dm_rv=%b dm_rdata=%h want 1 12345678", dm_rvalid, dm_rdata);
        end
      end
      next_cycle();
    end
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_lock = 0; dm_addr = 10'h030; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({if_gnt, dm_gnt, mem_we, mem_wdata} !== {1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL rmw_write: if_gnt=%b dm_gnt=%b we=%b wdata=%h want 0 1 1 deadbeef",
               if_gnt, dm_gnt, mem_we, mem_wdata);
    end
    next_cycle();
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    total++;
    if ({if_gnt, dm_rvalid, mem[10'h030]} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL rmw_release: if_gnt=%b dm_rv=%b mem030=%h want 1 0 deadbeef", if_gnt, dm_rvalid, mem[10'h030]);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_byte_write();
    mem[10'h040] = 32'h1122_3344;
    dm_req = 1; dm_we = 1; dm_be = 4'h2; dm_addr = 10'h040; dm_wdata = 32'h0000_AB00;
    @(negedge clk);
    total++;
    if ({dm_gnt, mem_we, mem_be, mem_wdata} !== {1'b1, 1'b1, 4'h2, 32'h0000_AB00}) begin
      bad++;
      $display("FAIL byte_write: gnt=%b we=%b be=%h wdata=%h want 1 1 2 0000ab00", dm_gnt, mem_we, mem_be, mem_wdata);
    end
    next_cycle();
    dm_we = 0; dm_be = 4'hF; dm_wdata = '0;
    @(negedge clk);
    total++;
    if ({dm_rvalid, if_rvalid, dm_gnt} !== 3'b001) begin
      bad++;
      $display("FAIL byte_write_norv: dm_rv=%b if_rv=%b dm_gnt=%b want 0 0 1", dm_rvalid, if_rvalid, dm_gnt);
    end
    next_cycle();
    dm_req = 0;
    @(negedge clk);
    total++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h1122_AB44}) begin
      bad++;
      $display("FAIL byte_readback: dm_rv=%b dm_rdata=%h want 1 1122ab44", dm_rvalid, dm_rdata);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    dm_req = 1; dm_we = 0; dm_lock = 1; dm_addr = 10'h040;
    @(negedge clk);
    total++;
    if (dm_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midrst_gnt: dm_gnt=%b want 1", dm_gnt);
    end
    #1 rst = 0;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) #1; else @(negedge clk);
      total++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_en, mem_we,
           mem_be, mem_addr, mem_wdata} !== '0) begin
        bad++;
        $display("FAIL midrst_outputs c=%0d: gnt=%b%b rv=%b%b en=%b addr=%h want all zero",
                 c, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_addr);
      end
    end
    next_cycle();
    rst = 1;
    drive_idle();
    if_req = 1; if_addr = 10'h013;
    @(negedge clk);
    total++;
    if ({if_gnt, dm_rvalid} !== 2'b10) begin
      bad++;
      $display("FAIL midrst_unlocked: if_gnt=%b dm_rv=%b want 1 0", if_gnt, dm_rvalid);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_random();
    bit            m_locked, m_if_pri, e_if, e_dm, p_if_rv, p_dm_rv;
    logic [DW-1:0] p_if_dat, p_dm_dat;
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    m_locked = 0; m_if_pri = 0; p_if_rv = 0; p_dm_rv = 0; p_if_dat = '0; p_dm_dat = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1; if_addr = 10'h0F0 + 10'($urandom_range(0, 15));
      end
      if (!dm_req && $urandom_range(0, 1) != 0) begin
        dm_req   = 1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_be    = 4'($urandom_range(1, 15));
        dm_addr  = 10'h0F0 + 10'($urandom_range(0, 15));
        dm_wdata = $urandom;
        dm_lock  = m_locked ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      end
      e_dm = m_locked ? dm_req : (dm_req && (!if_req || !(RR && m_if_pri)));
      e_if = !m_locked && if_req && !e_dm;
      @(negedge clk);
      total++;
      if ({if_gnt, dm_gnt, mem_en} !== {e_if, e_dm, e_if | e_dm}) begin
        bad++;
        $display("FAIL rand_gnt cyc=%0d: if_gnt=%b dm_gnt=%b en=%b want %b %b %b",
                 cyc, if_gnt, dm_gnt, mem_en, e_if, e_dm, e_if | e_dm);
      end
      total++;
      if ({mem_we, mem_be, mem_addr, mem_wdata} !==
          (e_dm ? {dm_we, dm_be, dm_addr, dm_wdata} :
           e_if ? {1'b0, 4'hF, if_addr, 32'h0} : {1'b0, 4'h0, 10'h0, 32'h0})) begin
        bad++;
        $display("FAIL rand_mem cyc=%0d: we=%b be=%h addr=%h wdata=%h", cyc, mem_we, mem_be, mem_addr, mem_wdata);
      end
      total++;
      if ({if_rvalid, if_rdata, dm_rvalid, dm_rdata} !==
          {p_if_rv, p_if_rv ? p_if_dat : 32'h0, p_dm_rv, p_dm_rv ? p_dm_dat : 32'h0}) begin
        bad++;
        $display("FAIL rand_rdata cyc=%0d: if=%b/%h dm=%b/%h want %b/%h %b/%h", cyc,
                 if_rvalid, if_rdata, dm_rvalid, dm_rdata, p_if_rv, p_if_dat, p_dm_rv, p_dm_dat);
      end
      p_if_rv  = e_if;
      p_if_dat = ref_mem[if_addr];
      p_dm_rv  = e_dm && !dm_we;
      p_dm_dat = ref_mem[dm_addr];
      if (e_dm && dm_we)
        for (int b = 0; b < BW; b++)
          if (dm_be[b]) ref_mem[dm_addr][8*b +: 8] = dm_wdata[8*b +: 8];
      if (!m_locked && if_req && dm_req) m_if_pri = e_dm;
      if (e_dm) m_locked = dm_lock;
      next_cycle();
      if (e_if) if_req = 0;
      if (e_dm) dm_req = 0;
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    drive_idle();
    test_reset();
    test_solo_fetch();
    test_conflict();
    test_locked_rmw();
    test_byte_write();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
